// File: rtl/mmio_disp_port_if.sv
// mmio_disp_port_if
// CPU data-bus view of the display/button peripheral.
//   addr        : CPU data address
//   MemWrite    : one-cycle store strobe
//   MemRead     : one-cycle load strobe
//   mem_data_in : store data from the CPU
//   rd_data     : load data returned by the peripheral (combinational)
//   sel         : peripheral address-window hit (combinational)
// The master modport is the CPU side; the slave modport is the peripheral.
interface mmio_disp_port_if;
  logic [31:0] addr;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] mem_data_in;
  logic [31:0] rd_data;
  logic        sel;

  modport master (
    output addr, MemWrite, MemRead, mem_data_in,
    input  rd_data, sel
  );

  modport slave (
    input  addr, MemWrite, MemRead, mem_data_in,
    output rd_data, sel
  );
endinterface

// File: rtl/mmio_disp_port.sv
// mmio_disp_port
// Memory-mapped display/button peripheral sitting in front of seven_seg_led.
// Decodes a 16-byte window on the CPU data bus and holds a double-buffered
// 24-bit display value, a per-digit blank mask, LED bits, a debounced
// push-button with a sticky press event and (optionally) a frame counter.
//
// Ports:
//   CLK        : system clock, all logic on posedge
//   reset      : synchronous active-high reset
//   bus        : CPU data bus (mmio_disp_port_if.slave)
//   frame_tick : one-cycle pulse at the start of each display scan frame
//   btn_in     : raw asynchronous push-button, active-high
//   disp_out   : active display value, digit 1 = [23:20]
//   blank_out  : per-digit blank, bit5 = digit 1
//   led_out    : discrete LED drive
//
// Register map (offset on addr[3:2]):
//   0x0 DISP  R/W  shadow[23:0]
//   0x4 CTRL  R/W  [5:0] blank, [8] freeze, [15:12] led
//   0x8 STAT  R    [0] level, [1] press event, [31:16] frame count
//   0xC       reads 0, writes ignored
//
// Optional feature macro: MMIO_DISP_FRAME_COUNT_EN builds the 16-bit frame
// counter returned in STAT[31:16]; without it those bits read 0.
module mmio_disp_port #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0,
  parameter int          DB_CYCLES = 1_000_000,
  parameter int          DB_W      = 20
) (
  input  logic                 CLK,
  input  logic                 reset,
  mmio_disp_port_if.slave      bus,
  input  logic                 frame_tick,
  input  logic                 btn_in,
  output logic [23:0]          disp_out,
  output logic [5:0]           blank_out,
  output logic [3:0]           led_out
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [23:0]     shadow;
  logic [23:0]     active;
  logic [5:0]      blank_mask;
  logic            freeze;
  logic [3:0]      led;
  logic            sync1;
  logic            sync2;
  logic            stable;
  logic            press;
  logic [DB_W-1:0] db_cnt;
  logic [15:0]     frame_cnt;

  logic            hit;
  logic            wr_disp;
  logic            wr_ctrl;
  logic            rd_stat;
  logic            db_done;
  logic            rise;
  logic [31:0]     rd_mux;

  // Bits of the bus that carry no information for this peripheral.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.addr[1:0], bus.mem_data_in[31:24],
                         bus.mem_data_in[11:9], bus.mem_data_in[7:6]};

  assign hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr_disp = bus.MemWrite & hit & (bus.addr[3:2] == 2'd0);
  assign wr_ctrl = bus.MemWrite & hit & (bus.addr[3:2] == 2'd1);
  assign rd_stat = bus.MemRead  & hit & (bus.addr[3:2] == 2'd2);

  // The debounce count has run out while the synchronised level still
  // disagrees with the accepted level; rise marks an accepted 0->1 change.
  assign db_done = (sync2 != stable) && (db_cnt == DB_LAST);
  assign rise    = db_done & sync2;

  // Zero-latency load mux; anything outside the window reads as 0.
  always_comb begin
    rd_mux = 32'h0;
    if (hit) begin
      case (bus.addr[3:2])
        2'd0:    rd_mux = {8'h0, shadow};
        2'd1:    rd_mux = {16'h0, led, 3'b000, freeze, 2'b00, blank_mask};
        2'd2:    rd_mux = {frame_cnt, 14'h0, press, stable};
        default: rd_mux = 32'h0;
      endcase
    end
  end

  assign bus.rd_data = rd_mux;
  assign bus.sel     = hit;

  // Bus-visible registers and the double-buffered display value.  The
  // active copy samples the shadow value from before any same-edge store,
  // so a store coinciding with a tick appears on the following tick.
  always_ff @(posedge CLK) begin
    if (reset) begin
      shadow     <= 24'h0;
      active     <= 24'h0;
      blank_mask <= 6'h0;
      freeze     <= 1'b0;
      led        <= 4'h0;
    end else begin
      if (frame_tick && !freeze)
        active <= shadow;
      if (wr_disp)
        shadow <= bus.mem_data_in[23:0];
      if (wr_ctrl) begin
        blank_mask <= bus.mem_data_in[5:0];
        freeze     <= bus.mem_data_in[8];
        led        <= bus.mem_data_in[15:12];
      end
    end
  end

  // Button synchroniser, debounce counter and sticky press event.  A new
  // press outranks a simultaneous STAT load so the event is never lost.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_done) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (rise)
        press <= 1'b1;
      else if (rd_stat)
        press <= 1'b0;
    end
  end

`ifdef MMIO_DISP_FRAME_COUNT_EN
  // Free-running scan-frame counter, independent of freeze.
  always_ff @(posedge CLK) begin
    if (reset)
      frame_cnt <= 16'h0;
    else if (frame_tick)
      frame_cnt <= frame_cnt + 16'h1;
  end
`else
  assign frame_cnt = 16'h0;
`endif

  assign disp_out  = active;
  assign blank_out = blank_mask;
  assign led_out   = led;

endmodule

// File: tb/tb_mmio_disp_port.sv
// tb_mmio_disp_port
// Directed self-checking bench for mmio_disp_port with DB_CYCLES=8.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled there as well, away from the active edge.
module tb_mmio_disp_port;

  localparam logic [31:0] A_DISP = 32'hFFFF_FFF0;
  localparam logic [31:0] A_CTRL = 32'hFFFF_FFF4;
  localparam logic [31:0] A_STAT = 32'hFFFF_FFF8;
  localparam logic [31:0] A_RSVD = 32'hFFFF_FFFC;
  localparam logic [31:0] A_OUT  = 32'h0000_1000;

  logic        CLK;
  logic        reset;
  logic        frame_tick;
  logic        btn_in;
  logic [23:0] disp_out;
  logic [5:0]  blank_out;
  logic [3:0]  led_out;

  int errors;
  int checks;

  mmio_disp_port_if bus ();

  mmio_disp_port #(
    .BASE_ADDR (32'hFFFF_FFF0),
    .DB_CYCLES (8),
    .DB_W      (4)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .bus        (bus.slave),
    .frame_tick (frame_tick),
    .btn_in     (btn_in),
    .disp_out   (disp_out),
    .blank_out  (blank_out),
    .led_out    (led_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr        = a;
    bus.mem_data_in = d;
    bus.MemWrite    = 1'b1;
    step();
    bus.MemWrite    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr    = a;
    bus.MemRead = 1'b1;
    #1;
    d = bus.rd_data;
    step();
    bus.MemRead = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  // Reset, with a store and tick active at the same time, must leave
  // every register clear.
  task automatic test_reset();
    logic [31:0] d;
    reset           = 1'b1;
    bus.addr        = A_DISP;
    bus.mem_data_in = 32'h00FF_FFFF;
    bus.MemWrite    = 1'b1;
    frame_tick      = 1'b1;
    steps(2);
    bus.MemWrite    = 1'b0;
    frame_tick      = 1'b0;
    reset           = 1'b0;
    step();
    bus_read(A_DISP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_disp got=%h exp=%h", d, 32'h0); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl got=%h exp=%h", d, 32'h0); end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_stat got=%h exp=%h", d, 32'h0); end
    bus_read(A_RSVD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsvd got=%h exp=%h", d, 32'h0); end
    checks++; if (disp_out !== 24'h0) begin errors++; $display("[TB] FAIL reset_disp_out got=%h exp=%h", disp_out, 24'h0); end
    checks++; if (blank_out !== 6'h0) begin errors++; $display("[TB] FAIL reset_blank got=%h exp=%h", blank_out, 6'h0); end
    checks++; if (led_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_led got=%h exp=%h", led_out, 4'h0); end
    bus.addr = A_OUT;
    #1;
    checks++; if (bus.sel !== 1'b0 || bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL outside_window sel=%b rd=%h exp sel=0 rd=0", bus.sel, bus.rd_data); end
    bus.addr = A_STAT;
    #1;
    checks++; if (bus.sel !== 1'b1) begin errors++; $display("[TB] FAIL inside_window sel=%b exp=1", bus.sel); end
  endtask

  // Shadow/active double buffering, including store coincident with tick.
  task automatic test_disp();
    logic [31:0] d;
    bus_write(A_DISP, 32'hFF_ABCDEF);
    bus_read(A_DISP, d);
    checks++; if (d !== 32'h00AB_CDEF) begin errors++; $display("[TB] FAIL disp_readback got=%h exp=%h", d, 32'h00AB_CDEF); end
    checks++; if (disp_out !== 24'h0) begin errors++; $display("[TB] FAIL disp_before_tick got=%h exp=%h", disp_out, 24'h0); end
    tick();
    checks++; if (disp_out !== 24'hABCDEF) begin errors++; $display("[TB] FAIL disp_after_tick got=%h exp=%h", disp_out, 24'hABCDEF); end
    bus.addr        = A_DISP;
    bus.mem_data_in = 32'h0012_3456;
    bus.MemWrite    = 1'b1;
    frame_tick      = 1'b1;
    step();
    bus.MemWrite    = 1'b0;
    frame_tick      = 1'b0;
    checks++; if (disp_out !== 24'hABCDEF) begin errors++; $display("[TB] FAIL disp_store_with_tick got=%h exp=%h", disp_out, 24'hABCDEF); end
    steps(2);
    checks++; if (disp_out !== 24'hABCDEF) begin errors++; $display("[TB] FAIL disp_wait_no_tick got=%h exp=%h", disp_out, 24'hABCDEF); end
    tick();
    checks++; if (disp_out !== 24'h123456) begin errors++; $display("[TB] FAIL disp_next_tick got=%h exp=%h", disp_out, 24'h123456); end
  endtask

  // CTRL fields, freeze holding the active value, ignored bits and writes.
  task automatic test_ctrl();
    logic [31:0] d;
    bus_write(A_CTRL, 32'h0000_A121);
    checks++; if (blank_out !== 6'h21 || led_out !== 4'hA) begin errors++; $display("[TB] FAIL ctrl_outputs blank=%h led=%h exp blank=21 led=a", blank_out, led_out); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0000_A121) begin errors++; $display("[TB] FAIL ctrl_readback got=%h exp=%h", d, 32'h0000_A121); end
    bus_write(A_DISP, 32'h0077_7777);
    tick(); tick(); tick();
    checks++; if (disp_out !== 24'h123456) begin errors++; $display("[TB] FAIL freeze_hold got=%h exp=%h", disp_out, 24'h123456); end
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0000_F13F) begin errors++; $display("[TB] FAIL ctrl_ignored_bits got=%h exp=%h", d, 32'h0000_F13F); end
    bus_write(A_RSVD, 32'hDEAD_BEEF);
    bus_write(A_STAT, 32'hFFFF_FFFF);
    bus_read(A_RSVD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rsvd_write_ignored got=%h exp=%h", d, 32'h0); end
    bus_read(A_DISP, d);
    checks++; if (d !== 32'h0077_7777) begin errors++; $display("[TB] FAIL disp_unaffected got=%h exp=%h", d, 32'h0077_7777); end
    bus_read(A_STAT, d);
    checks++; if (d[15:0] !== 16'h0) begin errors++; $display("[TB] FAIL stat_readonly got=%h exp=%h", d[15:0], 16'h0); end
    bus_write(A_CTRL, 32'h0);
    checks++; if (blank_out !== 6'h0 || led_out !== 4'h0) begin errors++; $display("[TB] FAIL ctrl_clear blank=%h led=%h exp 0 0", blank_out, led_out); end
    tick();
    checks++; if (disp_out !== 24'h777777) begin errors++; $display("[TB] FAIL unfreeze_tick got=%h exp=%h", disp_out, 24'h777777); end
  endtask

  // Glitch rejection, accepted press, sticky event cleared by a load.
  task automatic test_debounce();
    logic [31:0] d;
    btn_in = 1'b1;
    steps(5);
    btn_in = 1'b0;
    steps(20);
    bus_read(A_STAT, d);
    checks++; if (d[15:0] !== 16'h0) begin errors++; $display("[TB] FAIL glitch_rejected got=%h exp=%h", d[15:0], 16'h0); end
    btn_in = 1'b1;
    steps(20);
    bus_read(A_STAT, d);
    checks++; if (d[15:0] !== 16'h3) begin errors++; $display("[TB] FAIL press_first_read got=%h exp=%h", d[15:0], 16'h3); end
    bus_read(A_STAT, d);
    checks++; if (d[15:0] !== 16'h1) begin errors++; $display("[TB] FAIL press_second_read got=%h exp=%h", d[15:0], 16'h1); end
    btn_in = 1'b0;
    steps(20);
    bus_read(A_STAT, d);
    checks++; if (d[15:0] !== 16'h0) begin errors++; $display("[TB] FAIL release_no_event got=%h exp=%h", d[15:0], 16'h0); end
  endtask

  // Hold a STAT load across the whole debounce so the event is set on the
  // same edge as a clearing load; the set must survive.
  task automatic test_set_clear_same_cycle();
    logic [31:0] d;
    bit          found;
    int          n;
    found       = 1'b0;
    n           = 0;
    bus.addr    = A_STAT;
    bus.MemRead = 1'b1;
    btn_in      = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n++;
      if (bus.rd_data[0] === 1'b1) found = 1'b1;
    end
    bus.MemRead = 1'b0;
    checks++; if (!found) begin errors++; $display("[TB] FAIL set_clear_timeout level never rose within %0d cycles", n); end
    checks++; if (n !== 10) begin errors++; $display("[TB] FAIL button_latency got=%0d exp=%0d", n, 10); end
    bus_read(A_STAT, d);
    checks++; if (d[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL set_wins got=%b exp=%b", d[1:0], 2'b11); end
    btn_in = 1'b0;
    steps(20);
    bus_read(A_STAT, d);
  endtask

  // Reset in the middle of a debounce count restarts it from scratch.
  task automatic test_reset_midcount();
    logic [31:0] d;
    btn_in = 1'b1;
    steps(7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(7);
    bus_read(A_STAT, d);
    checks++; if (d[1:0] !== 2'b00) begin errors++; $display("[TB] FAIL reset_discards_count got=%b exp=%b", d[1:0], 2'b00); end
    steps(10);
    bus_read(A_STAT, d);
    checks++; if (d[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL recount_after_reset got=%b exp=%b", d[1:0], 2'b11); end
    btn_in = 1'b0;
    steps(20);
  endtask

  // Frame counter: counts ticks regardless of freeze and wraps.
  task automatic test_frame_count();
    logic [31:0] d;
    do_reset();
    bus_write(A_CTRL, 32'h0000_0100);
    tick(); tick(); tick();
    bus_read(A_STAT, d);
`ifdef MMIO_DISP_FRAME_COUNT_EN
    checks++; if (d[31:16] !== 16'd3) begin errors++; $display("[TB] FAIL frame_count_3 got=%h exp=%h", d[31:16], 16'd3); end
`else
    checks++; if (d[31:16] !== 16'd0) begin errors++; $display("[TB] FAIL frame_count_absent got=%h exp=%h", d[31:16], 16'd0); end
`endif
    do_reset();
    frame_tick = 1'b1;
    steps(65537);
    frame_tick = 1'b0;
    bus_read(A_STAT, d);
`ifdef MMIO_DISP_FRAME_COUNT_EN
    checks++; if (d[31:16] !== 16'd1) begin errors++; $display("[TB] FAIL frame_count_wrap got=%h exp=%h", d[31:16], 16'd1); end
`else
    checks++; if (d[31:16] !== 16'd0) begin errors++; $display("[TB] FAIL frame_count_absent_wrap got=%h exp=%h", d[31:16], 16'd0); end
`endif
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    frame_tick      = 1'b0;
    btn_in          = 1'b0;
    bus.addr        = 32'h0;
    bus.MemWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.mem_data_in = 32'h0;
    step();
    test_reset();
    test_disp();
    test_ctrl();
    test_debounce();
    test_set_clear_same_cycle();
    test_reset_midcount();
    test_frame_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_disp_port.md
# mmio_disp_port

Memory-mapped display/button peripheral on the cpucore data bus, directly upstream of `seven_seg_led`. It decodes CPU stores and loads to a 16-byte window and holds a double-buffered 24-bit display value, a digit blank mask and LED bits. It also debounces one push-button, so software can drive the six-digit display instead of the hard-wired `check` bus. The active display value changes only on a scan-frame boundary, so digits never tear mid-scan.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FFF0; window base, 16-byte aligned.
- `DB_CYCLES`, default 1_000_000; stable cycles required to accept a button level change, ≥2.
- `DB_W`, default 20; debounce counter width, must hold DB_CYCLES-1.
- `CLK`  in  1  system clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  32  CPU data address.
- `MemWrite`  in  1  store strobe, one cycle per store.
- `MemRead`  in  1  load strobe, one cycle per load.
- `mem_data_in`  in  32  store data from CPU.
- `rd_data`  out  32  load data, combinational from `addr`; 0 when `sel`=0.
- `sel`  out  1  combinational hit: `addr[31:4]==BASE_ADDR[31:4]`.
- `frame_tick`  in  1  one-cycle pulse at start of each display scan frame.
- `btn_in`  in  1  raw asynchronous push-button, active-high.
- `disp_out`  out  24  active display value to `seven_seg_led` (digit 1 = [23:20]).
- `blank_out`  out  6  per-digit blank, bit5 = digit 1.
- `led_out`  out  4  discrete LED drive.

## Operation
- Register offsets are decoded on `addr[3:2]`; `addr[1:0]` is ignored.
  - 0x0 DISP, R/W: shadow[23:0]; reads {8'h0, shadow}.
  - 0x4 CTRL, R/W: [5:0] blank mask, [8] freeze, [15:12] led; other bits read 0, writes ignored.
  - 0x8 STAT, R: [0] debounced level, [1] press event (sticky), [31:16] frame count; [15:2] read 0.
  - 0xC: reads 0, writes ignored.
- Store: when `MemWrite & sel`, the target register updates at that clock edge. STAT is read-only.
- Active register: at an edge where `frame_tick=1` and freeze=0, active ← shadow. `disp_out` = active. With freeze=1, active holds.
- `blank_out` = CTRL[5:0]. `led_out` = CTRL[15:12]. Both change the cycle after the store and do not wait for a frame.
- Debounce:
  - `btn_in` passes through a 2-flop synchroniser to give `s`.
  - While `s`==stable, counter=0. Otherwise counter increments each cycle.
  - When the counter reaches DB_CYCLES-1 with `s` still differing, stable ← s and counter ← 0.
  - A glitch shorter than DB_CYCLES resets the count and stable is unchanged.
- Press event:
  - Set on a stable 0→1 transition.
  - Cleared at an edge where `MemRead & sel & addr[3:2]==2`. That load returns the pre-clear value.
  - Set and clear in the same cycle: set wins, so the event stays 1.
- Frame count: 16-bit, +1 on each `frame_tick`, wraps FFFF→0000 and ignores freeze.

## Timing
- Reset values: shadow=0, active=0, CTRL=0, stable=0, event=0, counter=0, sync flops=0, frame count=0.
  - Hence `disp_out`=0, `blank_out`=0 (all digits lit) and `led_out`=0.
- Reset wins over every simultaneous write, tick or button activity. Reset during a debounce count discards it.
- Load latency is 0 cycles: `rd_data` is valid in the same cycle as `addr`.
- DISP store at edge N is visible on a read at N+1. It reaches `disp_out` at the first `frame_tick` edge strictly after N.
- DISP store and `frame_tick` at the same edge: active takes the old shadow; the new value moves at the next tick.
- Button latency from a `btn_in` edge to the stable change is 2 + DB_CYCLES cycles.

## Configuration
- `MMIO_DISP_FRAME_COUNT_EN`
  - Defined: the 16-bit frame counter exists and STAT[31:16] returns it.
  - Undefined: no counter is built and STAT[31:16] reads 0. All other behaviour is identical.

## Test plan
- Reset, then read all four offsets → 0, `disp_out`=0, `blank_out`=0, `led_out`=0.
- Store 0x00ABCDEF to DISP, read back → 0x00ABCDEF; `disp_out` stays 0 until the next `frame_tick`, then 0xABCDEF. Store 0x123456 together with a tick → `disp_out` unchanged until the following tick.
- Store CTRL=0x0000_A121 → `blank_out`=6'h21 and `led_out`=4'hA next cycle; freeze set. A DISP store of 0x777777 plus 3 ticks leaves `disp_out` at its prior value.
- With DB_CYCLES=8, pulse `btn_in` high 5 cycles → STAT=0. Hold it high 20 cycles → STAT[0]=1, STAT[1]=1. The first STAT read returns [1]=1, the second returns [1]=0.
- Force the press event and a STAT read in the same cycle → a subsequent read still shows [1]=1.
- With the macro defined, 65537 ticks → STAT[31:16]=1. With it undefined → STAT[31:16]=0 throughout.
